mem_port_arbiter: RTL and testbench

//  Shares the single-port synchronous program/data memory of the nano processor between two requesters:

---
 rtl/mem_port_arbiter_pkg.sv | 24 ++
 rtl/mem_arb_pick.sv | 35 +++
 rtl/mem_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter_pkg
//  Description : Shared types and constants for the nano processor memory
//                port arbiter: FSM state encoding and requester port indices.
//  Ports       : none (package)
//  Config      : MEMARB_RR_EN (consumed by mem_port_arbiter)
//  Revision    : 1.0  initial release
// ============================================================================
package mem_port_arbiter_pkg;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } arb_state_t;

    // Requester port indices
    localparam logic c_port_cpu = 1'b0;
    localparam logic c_port_ldr = 1'b1;

endpackage : mem_port_arbiter_pkg
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pick
//  Description : Combinational winner select for the two-port memory
//                arbiter. A lone requester always wins; on a tie the port
//                other than the last winner (i_ptr) is chosen.
//  Ports       : i_req0, i_req1 - port requests
//                i_ptr          - last-winner pointer (tie-break)
//                o_valid        - at least one request present
//                o_winner       - index of the selected port
//  Revision    : 1.0  initial release
// ============================================================================
module mem_arb_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_ptr,
    output logic o_valid,
    output logic o_winner
);

    always_comb begin
        o_valid = i_req0 | i_req1;
        if (i_req0 && i_req1) begin
            o_winner = ~i_ptr;
        end else if (i_req1) begin
            o_winner = c_port_ldr;
        end else begin
            o_winner = c_port_cpu;
        end
    end

endmodule : mem_arb_pick
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares the single-port synchronous program/data memory
//                between the CPU path (port 0) and the program loader /
//                debug port (port 1). Each access runs IDLE -> ACCESS
//                (-> RESP for reads) -> IDLE; read data is returned to the
//                port that won the access.
//  Ports       : clk, rst (async, active-low)
//                req0/we0/addr0/wdata0 -> gnt0/rvalid0/rdata0   port 0
//                req1/we1/addr1/wdata1 -> gnt1/rvalid1/rdata1   port 1
//                mem_en/mem_we/mem_addr/mem_wdata, mem_rdata    memory side
//                busy                                           not in IDLE
//  Config      : MEMARB_RR_EN defined   -> round-robin tie-break with a
//                                          1-bit last-winner pointer
//                MEMARB_RR_EN undefined -> fixed priority, port 1 > port 0
//  Revision    : 1.0  initial release
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    arb_state_t r_state;
    logic       r_port;     // port owning the access in flight
    logic       w_ptr;
    logic       w_valid;
    logic       w_winner;

`ifdef MEMARB_RR_EN
    logic r_ptr;

    // Last-winner pointer, moved on every grant (lone requester included)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= 1'b0;
        end else if (r_state == S_IDLE && w_valid) begin
            r_ptr <= w_winner;
        end
    end

    assign w_ptr = r_ptr;
`else
    // A pointer stuck at 0 makes every tie go to port 1
    assign w_ptr = 1'b0;
`endif

    mem_arb_pick u_pick (
        .i_req0   (req0),
        .i_req1   (req1),
        .i_ptr    (w_ptr),
        .o_valid  (w_valid),
        .o_winner (w_winner)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_port    <= c_port_cpu;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            // Grant and read-valid are single-cycle pulses
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_valid) begin
                        r_port  <= w_winner;
                        mem_en  <= 1'b1;
                        busy    <= 1'b1;
                        r_state <= S_ACCESS;
                        if (w_winner == c_port_ldr) begin
                            mem_we    <= we1;
                            mem_addr  <= addr1;
                            mem_wdata <= wdata1;
                            gnt1      <= 1'b1;
                        end else begin
                            mem_we    <= we0;
                            mem_addr  <= addr0;
                            mem_wdata <= wdata0;
                            gnt0      <= 1'b1;
                        end
                    end
                end
                S_ACCESS: begin
                    // Memory samples the access on this edge
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    if (mem_we) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (r_port == c_port_ldr) begin
                        rdata1  <= mem_rdata;
                        rvalid1 <= 1'b1;
                    end else begin
                        rdata0  <= mem_rdata;
                        rvalid0 <= 1'b1;
                    end
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    mem_en  <= 1'b0;
                    mem_we  <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Self-checking bench for mem_port_arbiter. Requesters are
//                driven from per-port transaction queues; a transaction-level
//                model predicts grant timing/winner, memory side values and
//                returned read data from a shadow memory.
//  Config      : MEMARB_RR_EN selects the round-robin expectations
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

    typedef struct packed {
        logic        we;
        logic [7:0]  addr;
        logic [15:0] data;
        logic [1:0]  gap;
    } txn_t;

    logic        clk;
    logic        rst;
    logic        req0, we0, req1, we1;
    logic [7:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        gnt0, rvalid0, gnt1, rvalid1;
    logic [15:0] rdata0, rdata1;
    logic        mem_en, mem_we, busy;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    // Environment memory (behaves like the synchronous macro)
    logic [15:0] mem [256];
    logic        ld_en;
    logic [7:0]  ld_addr;
    logic [15:0] ld_data;

    // Reference model state
    logic [15:0] ref_mem [256];
    txn_t        q0 [$];
    txn_t        q1 [$];
    int          m_wait;
    logic        m_last;

    int compared;
    int mismatched;

    mem_port_arbiter #(.ADDR_W(8), .DATA_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .we0       (we0),
        .addr0     (addr0),
        .wdata0    (wdata0),
        .gnt0      (gnt0),
        .rvalid0   (rvalid0),
        .rdata0    (rdata0),
        .req1      (req1),
        .we1       (we1),
        .addr1     (addr1),
        .wdata1    (wdata1),
        .gnt1      (gnt1),
        .rvalid1   (rvalid1),
        .rdata1    (rdata1),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end else if (mem_en && mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        if (mem_en && !mem_we) begin
            mem_rdata <= mem[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic txn_t mk(input logic we, input logic [7:0] a, input logic [15:0] d, input logic [1:0] g);
        txn_t t;
        t.we = we; t.addr = a; t.data = d; t.gap = g;
        return t;
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        t.we   = 1'($urandom_range(0, 1));
        t.addr = 8'($urandom_range(0, 15));
        t.data = 16'($urandom);
        t.gap  = 2'($urandom_range(0, 3));
        return t;
    endfunction

    function automatic int qsize(input int p);
        return (p == 1) ? q1.size() : q0.size();
    endfunction

    function automatic txn_t qhead(input int p);
        return (p == 1) ? q1[0] : q0[0];
    endfunction

    // Winner when both ports request at once
    function automatic int tie_winner();
`ifdef MEMARB_RR_EN
        return m_last ? 0 : 1;
`else
        return 1;
`endif
    endfunction

    // Plays both queues against the DUT; called and returns on a negedge
    task automatic run_engine(input int max_cyc);
        int          k;
        int          gapc [2];
        bit          pend [2];
        int          exp_p;
        int          busy_end;
        int          rv_due [2];
        logic [15:0] rv_dat [2];
        logic        rv;
        txn_t        et;
        txn_t        h;
        k = 0; exp_p = -1; busy_end = -1; et = '0;
        rv_due[0] = 0; rv_due[1] = 0; rv_dat[0] = '0; rv_dat[1] = '0;
        gapc[0] = (q0.size() > 0) ? int'(q0[0].gap) : 0;
        gapc[1] = (q1.size() > 0) ? int'(q1[0].gap) : 0;
        while (k < max_cyc) begin
            for (int p = 0; p < 2; p++) begin
                if (qsize(p) == 0) begin
                    pend[p] = 1'b0;
                end else if (gapc[p] > 0) begin
                    gapc[p]--;
                    pend[p] = 1'b0;
                end else begin
                    pend[p] = 1'b1;
                end
            end
            // Expected outcome of the next sampling edge
            exp_p = -1;
            if (m_wait > 0) begin
                m_wait--;
            end else if (pend[0] || pend[1]) begin
                exp_p    = (pend[0] && pend[1]) ? tie_winner() : (pend[1] ? 1 : 0);
                m_last   = exp_p[0];
                et       = qhead(exp_p);
                m_wait   = et.we ? 1 : 2;
                busy_end = k + 1 + (et.we ? 0 : 1);
                if (et.we) begin
                    ref_mem[et.addr] = et.data;
                end else begin
                    rv_due[exp_p] = k + 3;
                    rv_dat[exp_p] = ref_mem[et.addr];
                end
            end
            if (q0.size() > 0) begin h = q0[0]; we0 = h.we; addr0 = h.addr; wdata0 = h.data; end
            if (q1.size() > 0) begin h = q1[0]; we1 = h.we; addr1 = h.addr; wdata1 = h.data; end
            req0 = pend[0];
            req1 = pend[1];
            @(negedge clk);
            k++;
            chk("gnt0", 32'(gnt0), 32'(exp_p == 0));
            chk("gnt1", 32'(gnt1), 32'(exp_p == 1));
            chk("mem_en", 32'(mem_en), 32'(exp_p >= 0));
            chk("busy", 32'(busy), 32'(k <= busy_end));
            if (exp_p >= 0) begin
                chk("mem_we", 32'(mem_we), 32'(et.we));
                chk("mem_addr", 32'(mem_addr), 32'(et.addr));
                chk("mem_wdata", 32'(mem_wdata), 32'(et.data));
            end
            for (int p = 0; p < 2; p++) begin
                rv = (p == 1) ? rvalid1 : rvalid0;
                chk((p == 1) ? "rvalid1" : "rvalid0", 32'(rv), 32'(rv_due[p] == k));
                if (rv_due[p] == k) begin
                    chk((p == 1) ? "rdata1" : "rdata0", 32'((p == 1) ? rdata1 : rdata0), 32'(rv_dat[p]));
                    rv_due[p] = 0;
                end
            end
            // Requester side: move to the next transaction once granted
            if (gnt0 && q0.size() > 0) begin
                void'(q0.pop_front());
                gapc[0] = (q0.size() > 0) ? int'(q0[0].gap) : 0;
            end
            if (gnt1 && q1.size() > 0) begin
                void'(q1.pop_front());
                gapc[1] = (q1.size() > 0) ? int'(q1[0].gap) : 0;
            end
            if (q0.size() == 0 && q1.size() == 0 && m_wait == 0 && rv_due[0] == 0 && rv_due[1] == 0) begin
                break;
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        chk("engine_drain", 32'(q0.size() + q1.size() + rv_due[0] + rv_due[1]), 32'd0);
        q0.delete();
        q1.delete();
    endtask

    initial begin
        compared = 0; mismatched = 0;
        m_wait = 0; m_last = 1'b0;
        rst = 1'b0;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        mem_rdata = '0;

        // Preload memory contents while held in reset
        for (int i = 0; i < 256; i++) ref_mem[i] = 16'($urandom);
        ref_mem[8'h10] = 16'hA55A;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            ld_en = 1'b1; ld_addr = 8'(i); ld_data = ref_mem[i];
        end
        @(negedge clk);
        ld_en = 1'b0;

        // Reset state
        chk("rst_ctrl", 32'({gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we, busy}), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_rdata", 32'({rdata0, rdata1}), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Single read on port 0
        q0.push_back(mk(1'b0, 8'h10, 16'h0000, 2'd0));
        run_engine(50);

        // Write then read back on port 1
        q1.push_back(mk(1'b1, 8'h3F, 16'h1234, 2'd0));
        q1.push_back(mk(1'b0, 8'h3F, 16'h0000, 2'd0));
        run_engine(50);

        // Simultaneous reads, then both held for two accesses each
        q0.push_back(mk(1'b0, 8'h20, 16'h0, 2'd0));
        q1.push_back(mk(1'b0, 8'h21, 16'h0, 2'd0));
        run_engine(50);
        for (int i = 0; i < 2; i++) begin
            q0.push_back(mk(1'b0, 8'(8'h30 + i), 16'h0, 2'd0));
            q1.push_back(mk(1'b0, 8'(8'h40 + i), 16'h0, 2'd0));
        end
        run_engine(50);

        // Back-to-back reads on port 0
        for (int i = 0; i < 4; i++) q0.push_back(mk(1'b0, 8'(i), 16'h0, 2'd0));
        run_engine(50);

        // Reset during the RESP cycle of a port 0 read
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h05;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (gnt0) break;
        end
        chk("rr_gnt0", 32'(gnt0), 32'd1);
        req0 = 1'b0;
        @(negedge clk);
        chk("rr_busy_resp", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("rr_async_ctrl", 32'({gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we, busy}), 32'd0);
        chk("rr_async_data", 32'({mem_addr, mem_wdata, rdata0, rdata1}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        m_wait = 0; m_last = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rr_no_rvalid", 32'({rvalid0, busy}), 32'd0);
        end
        q0.push_back(mk(1'b0, 8'h05, 16'h0, 2'd0));
        run_engine(50);

        // Idle for 20 cycles
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle", 32'({mem_en, busy, gnt0, gnt1, rvalid0, rvalid1}), 32'd0);
        end

        // Randomised mixed traffic on both ports
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 6; i++) begin
                q0.push_back(rand_txn());
                q1.push_back(rand_txn());
            end
            run_engine(300);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_mem_port_arbiter
`default_nettype wire
